// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin arbiter that shares one UDP core TX interface
// (header handshake + byte-wide payload stream) between PORTS requesters.
module udp_tx_arbiter #(
  parameter int         PORTS = 2,
  parameter logic [7:0] TTL   = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS-1:0]      s_hdr_valid,
  output logic [PORTS-1:0]      s_hdr_ready,
  input  logic [32*PORTS-1:0]   s_dest_ip,
  input  logic [16*PORTS-1:0]   s_source_port,
  input  logic [16*PORTS-1:0]   s_dest_port,
  input  logic [16*PORTS-1:0]   s_length,
  input  logic [8*PORTS-1:0]    s_payload_tdata,
  input  logic [PORTS-1:0]      s_payload_tvalid,
  input  logic [PORTS-1:0]      s_payload_tlast,
  input  logic [PORTS-1:0]      s_payload_tuser,
  output logic [PORTS-1:0]      s_payload_tready,
  input  logic [31:0]           local_ip,
  output logic                  m_hdr_valid,
  input  logic                  m_hdr_ready,
  output logic [5:0]            m_ip_dscp,
  output logic [1:0]            m_ip_ecn,
  output logic [7:0]            m_ip_ttl,
  output logic [31:0]           m_source_ip,
  output logic [31:0]           m_dest_ip,
  output logic [15:0]           m_source_port,
  output logic [15:0]           m_dest_port,
  output logic [15:0]           m_length,
  output logic [15:0]           m_checksum,
  output logic [7:0]            m_payload_tdata,
  output logic                  m_payload_tvalid,
  output logic                  m_payload_tlast,
  output logic                  m_payload_tuser,
  input  logic                  m_payload_tready,
  output logic [PORTS-1:0]      grant,
  output logic                  busy
);

  localparam int             IW        = (PORTS > 2) ? 2 : 1;
  localparam logic [IW-1:0]  LAST_PORT = IW'(PORTS - 1);
  localparam logic [15:0]    UDP_HDR_BYTES = 16'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     lastOwner_q, lastOwner_d;
  logic [31:0]       destIp_q, destIp_d;
  logic [31:0]       srcIp_q, srcIp_d;
  logic [15:0]       srcPort_q, srcPort_d;
  logic [15:0]       dstPort_q, dstPort_d;
  logic [15:0]       length_q, length_d;
  logic [1:0]        rstSync_q;

  logic              arbEnable;
  logic              pickFound;
  logic [IW-1:0]     pickIdx;
  logic [IW-1:0]     cand;
  logic [31:0]       winDestIp;
  logic [15:0]       winSrcPort;
  logic [15:0]       winDstPort;
  logic [15:0]       winLength;
  logic [7:0]        ownData;
  logic              ownValid;
  logic              ownLast;
  logic              ownUser;
  logic              frameEnd;

  // Assertion is immediate through the async clear; release ripples through two
  // flops so arbitration never races the reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign arbEnable = rstSync_q[1];

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = IW'((int'(lastOwner_q) + i) % PORTS);
      if (!pickFound && s_hdr_valid[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_comb begin
    winDestIp  = '0;
    winSrcPort = '0;
    winDstPort = '0;
    winLength  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (pickIdx == IW'(p)) begin
        winDestIp  = s_dest_ip[32*p +: 32];
        winSrcPort = s_source_port[16*p +: 16];
        winDstPort = s_dest_port[16*p +: 16];
        winLength  = s_length[16*p +: 16];
      end
    end
  end

  always_comb begin
    ownData  = '0;
    ownValid = 1'b0;
    ownLast  = 1'b0;
    ownUser  = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (owner_q == IW'(p)) begin
        ownData  = s_payload_tdata[8*p +: 8];
        ownValid = s_payload_tvalid[p];
        ownLast  = s_payload_tlast[p];
        ownUser  = s_payload_tuser[p];
      end
    end
  end

  assign frameEnd = (state_q == PAYLOAD) && ownValid && m_payload_tready && ownLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      lastOwner_q <= LAST_PORT;
      destIp_q    <= '0;
      srcIp_q     <= '0;
      srcPort_q   <= '0;
      dstPort_q   <= '0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      destIp_q    <= destIp_d;
      srcIp_q     <= srcIp_d;
      srcPort_q   <= srcPort_d;
      dstPort_q   <= dstPort_d;
      length_q    <= length_d;
    end
  end

  // The header is snapshotted at grant time so a requester may drop its
  // request or change fields afterwards without disturbing the frame.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    destIp_d    = destIp_q;
    srcIp_d     = srcIp_q;
    srcPort_d   = srcPort_q;
    dstPort_d   = dstPort_q;
    length_d    = length_q;
    case (state_q)
      IDLE: begin
        if (arbEnable && pickFound) begin
          state_d          = HDR;
          owner_d          = pickIdx;
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          destIp_d         = winDestIp;
          srcIp_d          = local_ip;
          srcPort_d        = winSrcPort;
          dstPort_d        = winDstPort;
          length_d         = winLength + UDP_HDR_BYTES;
        end
      end
      HDR: begin
        if (m_hdr_ready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (frameEnd) begin
          state_d     = IDLE;
          lastOwner_d = owner_q;
          grant_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_hdr_ready      = '0;
    s_payload_tready = '0;
    m_payload_tdata  = ownData;
    m_payload_tvalid = 1'b0;
    m_payload_tlast  = 1'b0;
    m_payload_tuser  = 1'b0;
    if (state_q == HDR) begin
      s_hdr_ready = grant_q & {PORTS{m_hdr_ready}};
    end
    if (state_q == PAYLOAD) begin
      s_payload_tready = grant_q & {PORTS{m_payload_tready}};
      m_payload_tvalid = ownValid;
      m_payload_tlast  = ownLast;
      m_payload_tuser  = ownUser;
    end
  end

  assign m_hdr_valid   = (state_q == HDR);
  assign m_ip_dscp     = '0;
  assign m_ip_ecn      = '0;
  assign m_ip_ttl      = TTL;
  assign m_checksum    = '0;
  assign m_source_ip   = srcIp_q;
  assign m_dest_ip     = destIp_q;
  assign m_source_port = srcPort_q;
  assign m_dest_port   = dstPort_q;
  assign m_length      = length_q;
  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: per-port requester models feed the DUT,
// a scoreboard of expected headers/beats is compared at each core-side handshake.
module tb_udp_tx_arbiter;

  localparam int          P        = 2;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0A01;

  typedef struct {
    logic [31:0] dest;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] len;
  } hdr_t;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [P-1:0] grant;
    hdr_t         h;
  } expHdr_t;

  typedef struct {
    logic [P-1:0] grant;
    beat_t        b;
  } expBeat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [P-1:0]      s_hdr_valid;
  logic [P-1:0]      s_hdr_ready;
  logic [32*P-1:0]   s_dest_ip;
  logic [16*P-1:0]   s_source_port;
  logic [16*P-1:0]   s_dest_port;
  logic [16*P-1:0]   s_length;
  logic [8*P-1:0]    s_payload_tdata;
  logic [P-1:0]      s_payload_tvalid;
  logic [P-1:0]      s_payload_tlast;
  logic [P-1:0]      s_payload_tuser;
  logic [P-1:0]      s_payload_tready;
  logic [31:0]       local_ip;
  logic              m_hdr_valid;
  logic              m_hdr_ready;
  logic [5:0]        m_ip_dscp;
  logic [1:0]        m_ip_ecn;
  logic [7:0]        m_ip_ttl;
  logic [31:0]       m_source_ip;
  logic [31:0]       m_dest_ip;
  logic [15:0]       m_source_port;
  logic [15:0]       m_dest_port;
  logic [15:0]       m_length;
  logic [15:0]       m_checksum;
  logic [7:0]        m_payload_tdata;
  logic              m_payload_tvalid;
  logic              m_payload_tlast;
  logic              m_payload_tuser;
  logic              m_payload_tready;
  logic [P-1:0]      grant;
  logic              busy;

  hdr_t     hdrQ[P][$];
  beat_t    payQ[P][$];
  expHdr_t  expHdrQ[$];
  expBeat_t expPayQ[$];
  expHdr_t  monHdr;
  expBeat_t monBeat;
  logic     readyToggle;
  int       checks = 0;
  int       failures = 0;
  int       beatsSeen = 0;

  udp_tx_arbiter #(.PORTS(P), .TTL(8'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_dest_ip(s_dest_ip), .s_source_port(s_source_port), .s_dest_port(s_dest_port),
    .s_length(s_length),
    .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
    .s_payload_tlast(s_payload_tlast), .s_payload_tuser(s_payload_tuser),
    .s_payload_tready(s_payload_tready),
    .local_ip(local_ip),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_ttl(m_ip_ttl),
    .m_source_ip(m_source_ip), .m_dest_ip(m_dest_ip),
    .m_source_port(m_source_port), .m_dest_port(m_dest_port),
    .m_length(m_length), .m_checksum(m_checksum),
    .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
    .m_payload_tlast(m_payload_tlast), .m_payload_tuser(m_payload_tuser),
    .m_payload_tready(m_payload_tready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mkBeat(input int k, input int n, input logic [7:0] seed);
    beat_t b;
    b.data = seed + 8'(k);
    b.last = (k == n - 1);
    b.user = (k == n - 1) ? seed[7] : b.data[0];
    return b;
  endfunction

  task automatic applyStimulus(input int port, input logic [31:0] dest, input logic [15:0] sport,
                               input logic [15:0] dport, input logic [15:0] len,
                               input int nbytes, input logic [7:0] seed);
    hdr_t h;
    h.dest  = dest;
    h.sport = sport;
    h.dport = dport;
    h.len   = len;
    hdrQ[port].push_back(h);
    for (int k = 0; k < nbytes; k++) payQ[port].push_back(mkBeat(k, nbytes, seed));
  endtask

  task automatic expectFrame(input int port, input logic [31:0] dest, input logic [15:0] sport,
                             input logic [15:0] dport, input logic [15:0] expLen,
                             input int nbytes, input logic [7:0] seed);
    expHdr_t  e;
    expBeat_t b;
    e.grant       = '0;
    e.grant[port] = 1'b1;
    e.h.dest      = dest;
    e.h.sport     = sport;
    e.h.dport     = dport;
    e.h.len       = expLen;
    expHdrQ.push_back(e);
    for (int k = 0; k < nbytes; k++) begin
      b.grant = e.grant;
      b.b     = mkBeat(k, nbytes, seed);
      expPayQ.push_back(b);
    end
  endtask

  task automatic driveInputs();
    for (int p = 0; p < P; p++) begin
      s_hdr_valid[p]             = (hdrQ[p].size() > 0);
      s_dest_ip[32*p +: 32]      = (hdrQ[p].size() > 0) ? hdrQ[p][0].dest  : 32'h0;
      s_source_port[16*p +: 16]  = (hdrQ[p].size() > 0) ? hdrQ[p][0].sport : 16'h0;
      s_dest_port[16*p +: 16]    = (hdrQ[p].size() > 0) ? hdrQ[p][0].dport : 16'h0;
      s_length[16*p +: 16]       = (hdrQ[p].size() > 0) ? hdrQ[p][0].len   : 16'h0;
      s_payload_tvalid[p]        = (payQ[p].size() > 0);
      s_payload_tdata[8*p +: 8]  = (payQ[p].size() > 0) ? payQ[p][0].data : 8'h0;
      s_payload_tlast[p]         = (payQ[p].size() > 0) ? payQ[p][0].last : 1'b0;
      s_payload_tuser[p]         = (payQ[p].size() > 0) ? payQ[p][0].user : 1'b0;
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((expHdrQ.size() != 0 || expPayQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(expHdrQ.size() + expPayQ.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Requester models: handshakes are sampled mid-cycle and retired after the edge.
  initial begin
    logic [P-1:0] hHs;
    logic [P-1:0] pHs;
    m_payload_tready = 1'b1;
    driveInputs();
    forever begin
      @(negedge clk);
      hHs = s_hdr_valid & s_hdr_ready;
      pHs = s_payload_tvalid & s_payload_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < P; p++) begin
        if (rst_n && hHs[p] && hdrQ[p].size() > 0) hdrQ[p].delete(0);
        if (rst_n && pHs[p] && payQ[p].size() > 0) payQ[p].delete(0);
      end
      m_payload_tready = readyToggle ? ~m_payload_tready : 1'b1;
      driveInputs();
    end
  end

  // Scoreboard: every core-side handshake pops and compares the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_hdr_valid && m_hdr_ready) begin
        checkOutput("hdr expected", 64'(expHdrQ.size() > 0), 64'd1);
        if (expHdrQ.size() > 0) begin
          monHdr = expHdrQ.pop_front();
          checkOutput("hdr grant", 64'(grant), 64'(monHdr.grant));
          checkOutput("hdr dest ip", 64'(m_dest_ip), 64'(monHdr.h.dest));
          checkOutput("hdr source port", 64'(m_source_port), 64'(monHdr.h.sport));
          checkOutput("hdr dest port", 64'(m_dest_port), 64'(monHdr.h.dport));
          checkOutput("hdr length", 64'(m_length), 64'(monHdr.h.len));
          checkOutput("hdr source ip", 64'(m_source_ip), 64'(LOCAL_IP));
          checkOutput("hdr ttl/dscp/ecn/csum", {32'h0, m_ip_ttl, m_ip_dscp, m_ip_ecn, m_checksum},
                      {32'h0, 8'd64, 6'd0, 2'd0, 16'd0});
        end
      end
      if (m_payload_tvalid && m_payload_tready) begin
        checkOutput("beat expected", 64'(expPayQ.size() > 0), 64'd1);
        if (expPayQ.size() > 0) begin
          monBeat = expPayQ.pop_front();
          beatsSeen++;
          checkOutput("beat user/last/data", 64'({m_payload_tuser, m_payload_tlast, m_payload_tdata}),
                      64'(monBeat.b));
          checkOutput("beat grant", 64'(grant), 64'(monBeat.grant));
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    rst_n       = 1'b1;
    m_hdr_ready = 1'b1;
    readyToggle = 1'b0;
    local_ip    = LOCAL_IP;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset busy/grant/hvalid/pvalid", {busy, grant, m_hdr_valid, m_payload_tvalid}, '0);
    checkOutput("reset readies", {s_hdr_ready, s_payload_tready}, '0);
    checkOutput("reset header regs", {m_dest_ip, m_length, m_source_port}, '0);
    checkOutput("reset ttl", 64'(m_ip_ttl), 64'd64);

    // Simultaneous requests after reset: port 0 first, then port 1.
    applyStimulus(0, 32'h0A00_0001, 16'd1000, 16'd2000, 16'd4, 4, 8'h10);
    applyStimulus(1, 32'h0A00_0002, 16'd1001, 16'd2001, 16'd4, 4, 8'h21);
    expectFrame(0, 32'h0A00_0001, 16'd1000, 16'd2000, 16'd12, 4, 8'h10);
    expectFrame(1, 32'h0A00_0002, 16'd1001, 16'd2001, 16'd12, 4, 8'h21);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("no arbitration on first edge after release", 64'(busy), 64'd0);
    drain(200, "t1 drain");

    // Port 1 streams two frames; port 0 joins mid-frame and wins next.
    applyStimulus(1, 32'h0B00_0001, 16'd3000, 16'd4000, 16'd5, 5, 8'h30);
    applyStimulus(1, 32'h0B00_0002, 16'd3001, 16'd4001, 16'd5, 5, 8'h50);
    expectFrame(1, 32'h0B00_0001, 16'd3000, 16'd4000, 16'd13, 5, 8'h30);
    n = 0;
    while (!(grant === 2'b10 && busy === 1'b1 && m_hdr_valid === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t2 port1 owns payload", 64'({grant, busy, m_hdr_valid}), 64'b1010);
    applyStimulus(0, 32'h0C00_0001, 16'd5000, 16'd6000, 16'd3, 3, 8'h70);
    expectFrame(0, 32'h0C00_0001, 16'd5000, 16'd6000, 16'd11, 3, 8'h70);
    expectFrame(1, 32'h0B00_0002, 16'd3001, 16'd4001, 16'd13, 5, 8'h50);
    drain(300, "t2 drain");

    // Header stall with early payload, then a toggling payload ready.
    m_hdr_ready = 1'b0;
    applyStimulus(0, 32'h0D00_0001, 16'd7000, 16'd8000, 16'd4, 4, 8'h90);
    expectFrame(0, 32'h0D00_0001, 16'd7000, 16'd8000, 16'd12, 4, 8'h90);
    n = 0;
    while (m_hdr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t3 hdr valid raised", 64'(m_hdr_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      checkOutput("t3 stall hvalid", 64'(m_hdr_valid), 64'd1);
      checkOutput("t3 stall header", {m_dest_ip, m_length, m_source_port}, {32'h0D00_0001, 16'd12, 16'd7000});
      checkOutput("t3 stall readies", {s_hdr_ready, s_payload_tready}, '0);
      checkOutput("t3 stall pvalid", 64'(m_payload_tvalid), 64'd0);
      @(negedge clk);
    end
    readyToggle = 1'b1;
    m_hdr_ready = 1'b1;
    drain(200, "t3 drain");
    readyToggle = 1'b0;

    // Length wrap on a 16-bit sum.
    applyStimulus(0, 32'h0E00_0001, 16'd9000, 16'd9001, 16'hFFFA, 2, 8'hA1);
    expectFrame(0, 32'h0E00_0001, 16'd9000, 16'd9001, 16'h0002, 2, 8'hA1);
    drain(200, "t4 drain");

    // Reset in the middle of a port 1 payload, then port 0 wins the first frame.
    base = beatsSeen;
    applyStimulus(1, 32'h0F00_0001, 16'd1111, 16'd2222, 16'd6, 6, 8'hC0);
    expectFrame(1, 32'h0F00_0001, 16'd1111, 16'd2222, 16'd14, 6, 8'hC0);
    n = 0;
    while (beatsSeen < base + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("t5 two beats before reset", 64'(beatsSeen >= base + 2), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5 async busy/grant/hvalid/pvalid", {busy, grant, m_hdr_valid, m_payload_tvalid}, '0);
    checkOutput("t5 async readies", {s_hdr_ready, s_payload_tready}, '0);
    checkOutput("t5 async header regs", {m_dest_ip, m_length, m_source_port}, '0);
    expHdrQ.delete();
    expPayQ.delete();
    for (int p = 0; p < P; p++) begin
      hdrQ[p].delete();
      payQ[p].delete();
    end
    repeat (3) @(posedge clk);
    applyStimulus(1, 32'h1000_0001, 16'd1212, 16'd3434, 16'd3, 3, 8'hD0);
    applyStimulus(0, 32'h1000_0002, 16'd5656, 16'd7878, 16'd3, 3, 8'hE0);
    expectFrame(0, 32'h1000_0002, 16'd5656, 16'd7878, 16'd11, 3, 8'hE0);
    expectFrame(1, 32'h1000_0001, 16'd1212, 16'd3434, 16'd11, 3, 8'hD0);
    #1 rst_n = 1'b1;
    drain(200, "t5 drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
